// File: rtl/usb_protocol_fsm.sv
// Host-side USB transaction engine: token (+OUT data) out, handshake or IN data back, bounded retries.
// Define USB_PTCL_ERR_CNT_EN to build the saturating attempt-failure counter on err_cnt.
module usb_protocol_fsm #(
  parameter int MAX_ATTEMPT = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xfer_req,
  input  logic [18:0] token_pkt_in,
  input  logic [71:0] data_pkt_in,
  output logic        ptcl_ready,
  output logic        ptcl_done,
  output logic        ptcl_success,
  output logic [63:0] ptcl_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  tx_kind,
  output logic [71:0] tx_pkt,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [7:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok,
  output logic [7:0]  err_cnt
);

  // state     | meaning
  // IDLE      | ready for a request
  // TX_TOKEN  | token offered to encoder
  // WAIT_TX   | token accepted, waiting for tx_done
  // TX_DATA   | OUT data offered, then waiting for its tx_done (sent=1)
  // WAIT_HS   | waiting for device handshake after OUT data
  // WAIT_DATA | waiting for device DATA after IN token
  // TX_HS     | ACK/NAK offered, then waiting for its tx_done (sent=1)
  // DONE      | ptcl_done pulse, result valid

  localparam logic [7:0] PID_OUT  = 8'b10000111;
  localparam logic [7:0] PID_ACK  = 8'b01001011;
  localparam logic [7:0] PID_NAK  = 8'b01011010;
  localparam logic [7:0] PID_DATA = 8'b11000011;
  localparam int AW = $clog2(MAX_ATTEMPT + 1);
  localparam logic [AW-1:0]   ATT_MAX = AW'(MAX_ATTEMPT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, TX_TOKEN, WAIT_TX, TX_DATA, WAIT_HS, WAIT_DATA, TX_HS, DONE
  } state_t;

  state_t          state;
  logic [18:0]     tok_q;
  logic [71:0]     dat_q;
  logic [AW-1:0]   attempt;
  logic [TO_W-1:0] timer;
  logic            sent;
  logic            hs_ack;
  logic            timed_out;
  logic            pass_evt;
  logic            fail_evt;

  assign timed_out = (timer == TO_LAST);

  // Terminal outcomes of one attempt; a response arriving on the expiry cycle takes priority.
  always_comb begin
    pass_evt = 1'b0;
    fail_evt = 1'b0;
    case (state)
      WAIT_HS: begin
        if (rx_valid) begin
          if (rx_pid == PID_ACK) pass_evt = 1'b1;
          else                   fail_evt = 1'b1;
        end else if (timed_out) begin
          fail_evt = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_pid != PID_DATA) fail_evt = 1'b1;
        end else if (timed_out) begin
          fail_evt = 1'b1;
        end
      end
      TX_HS: begin
        if (sent && tx_done) begin
          if (hs_ack) pass_evt = 1'b1;
          else        fail_evt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptcl_ready   <= 1'b1;
      ptcl_done    <= 1'b0;
      ptcl_success <= 1'b0;
      ptcl_data    <= '0;
      tx_valid     <= 1'b0;
      tx_kind      <= 2'b00;
      tx_pkt       <= '0;
      tok_q        <= '0;
      dat_q        <= '0;
      attempt      <= '0;
      timer        <= '0;
      sent         <= 1'b0;
      hs_ack       <= 1'b0;
    end else begin
      ptcl_done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_req) begin
            tok_q        <= token_pkt_in;
            dat_q        <= data_pkt_in;
            attempt      <= AW'(1);
            ptcl_ready   <= 1'b0;
            ptcl_success <= 1'b0;
            tx_valid     <= 1'b1;
            tx_kind      <= 2'b00;
            tx_pkt       <= {53'b0, token_pkt_in};
            state        <= TX_TOKEN;
          end
        end
        TX_TOKEN: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            if (tok_q[18:11] == PID_OUT) begin
              tx_valid <= 1'b1;
              tx_kind  <= 2'b01;
              tx_pkt   <= dat_q;
              state    <= TX_DATA;
            end else begin
              timer <= '0;
              state <= WAIT_DATA;
            end
          end
        end
        TX_DATA: begin
          if (!sent) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              sent     <= 1'b1;
            end
          end else if (tx_done) begin
            sent  <= 1'b0;
            timer <= '0;
            state <= WAIT_HS;
          end
        end
        WAIT_HS: timer <= timer + TO_W'(1);
        WAIT_DATA: begin
          timer <= timer + TO_W'(1);
          if (rx_valid && rx_pid == PID_DATA) begin
            hs_ack <= rx_crc_ok;
            if (rx_crc_ok) ptcl_data <= rx_data;
            tx_valid <= 1'b1;
            tx_kind  <= 2'b10;
            tx_pkt   <= {64'b0, (rx_crc_ok ? PID_ACK : PID_NAK)};
            state    <= TX_HS;
          end
        end
        TX_HS: begin
          if (!sent) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              sent     <= 1'b1;
            end
          end else if (tx_done) begin
            sent <= 1'b0;
          end
        end
        DONE: begin
          ptcl_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pass_evt) begin
        state        <= DONE;
        ptcl_done    <= 1'b1;
        ptcl_success <= 1'b1;
      end else if (fail_evt) begin
        if (attempt < ATT_MAX) begin
          attempt  <= attempt + AW'(1);
          tx_valid <= 1'b1;
          tx_kind  <= 2'b00;
          tx_pkt   <= {53'b0, tok_q};
          state    <= TX_TOKEN;
        end else begin
          state        <= DONE;
          ptcl_done    <= 1'b1;
          ptcl_success <= 1'b0;
        end
      end
    end
  end

`ifdef USB_PTCL_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst)                           err_q <= '0;
    else if (fail_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Randomized bench for usb_protocol_fsm: emulated encoder/decoder plus a per-request outcome model.
module tb_usb_protocol_fsm;

  localparam logic [7:0] PID_OUT   = 8'h87;
  localparam logic [7:0] PID_IN    = 8'h96;
  localparam logic [7:0] PID_ACK   = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA  = 8'hC3;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam int MAX_ATT = 8;
  localparam int R_ACK = 0, R_NAK = 1, R_OTHER = 2, R_NONE = 3, R_DGOOD = 4, R_DBAD = 5;

`ifdef USB_PTCL_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, rst, xfer_req;
  logic [18:0] token_pkt_in;
  logic [71:0] data_pkt_in;
  logic        ptcl_ready, ptcl_done, ptcl_success;
  logic [63:0] ptcl_data;
  logic        tx_valid, tx_ready, tx_done;
  logic [1:0]  tx_kind;
  logic [71:0] tx_pkt;
  logic        rx_valid, rx_crc_ok;
  logic [7:0]  rx_pid, err_cnt;
  logic [63:0] rx_data;

  usb_protocol_fsm dut (
    .clk(clk), .rst(rst), .xfer_req(xfer_req), .token_pkt_in(token_pkt_in),
    .data_pkt_in(data_pkt_in), .ptcl_ready(ptcl_ready), .ptcl_done(ptcl_done),
    .ptcl_success(ptcl_success), .ptcl_data(ptcl_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_kind(tx_kind), .tx_pkt(tx_pkt), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_crc_ok(rx_crc_ok),
    .err_cnt(err_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int script[MAX_ATT];
  logic [63:0] rsp_data[MAX_ATT];
  int tok_seen;
  int done_cnt;
  int force_rdly = -1;
  logic [73:0] obs_q[$];
  logic [73:0] exp_q[$];
  int tok_cyc[$];
  bit exp_succ;
  int exp_fails;
  int exp_err = 0;
  logic [63:0] exp_data = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Encoder/decoder emulation: random ready/done latency, scripted device responses.
  initial begin : env
    int phase, cnt, rcnt, ridx;
    bit rpend;
    logic [73:0] hold;
    phase = 0; cnt = 0; rcnt = 0; ridx = 0; rpend = 0; hold = '0;
    forever begin
      @(negedge clk);
      tx_ready  = 1'b0;
      tx_done   = 1'b0;
      rx_valid  = 1'b0;
      rx_pid    = 8'($urandom);
      rx_data   = {$urandom, $urandom};
      rx_crc_ok = 1'($urandom);
      if (rst) begin
        phase = 0;
        rpend = 0;
      end else begin
        if (phase == 0 && tx_valid) begin
          hold  = {tx_kind, tx_pkt};
          cnt   = (force_rdly >= 0) ? force_rdly : $urandom_range(0, 3);
          phase = 1;
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            chk("tx_stable", {tx_valid, tx_kind, tx_pkt}, {1'b1, hold});
            tx_ready = 1'b1;
            obs_q.push_back(hold);
            if (hold[73:72] == 2'b00) tok_cyc.push_back(cyc);
            cnt   = $urandom_range(1, 4);
            phase = 2;
          end else begin
            cnt--;
          end
        end else if (phase == 2) begin
          if (cnt == 0) begin
            tx_done = 1'b1;
            phase   = 0;
            done_cnt++;
            if (hold[73:72] == 2'b00) begin
              ridx = (tok_seen < MAX_ATT) ? tok_seen : MAX_ATT - 1;
              tok_seen++;
              if (hold[18:11] == PID_IN) begin
                rpend = (script[ridx] != R_NONE);
                rcnt  = $urandom_range(1, 5);
              end
            end else if (hold[73:72] == 2'b01) begin
              rpend = (script[ridx] != R_NONE);
              rcnt  = $urandom_range(1, 5);
            end
          end else begin
            cnt--;
          end
        end
        if (rpend) begin
          if (rcnt == 0) begin
            rpend    = 0;
            rx_valid = 1'b1;
            case (script[ridx])
              R_ACK:   rx_pid = PID_ACK;
              R_NAK:   rx_pid = PID_NAK;
              R_DGOOD: begin rx_pid = PID_DATA; rx_data = rsp_data[ridx]; rx_crc_ok = 1'b1; end
              R_DBAD:  begin rx_pid = PID_DATA; rx_crc_ok = 1'b0; end
              default: rx_pid = PID_STALL;
            endcase
          end else begin
            rcnt--;
          end
        end
      end
    end
  end

  // Outcome of one request from its response script: emitted packets, result, failed attempts.
  task automatic predict(input bit is_out, input logic [18:0] tok, input logic [71:0] dat);
    exp_q.delete();
    exp_succ  = 0;
    exp_fails = 0;
    for (int a = 0; a < MAX_ATT && !exp_succ; a++) begin
      exp_q.push_back({2'b00, 53'b0, tok});
      if (is_out) begin
        exp_q.push_back({2'b01, dat});
        if (script[a] == R_ACK) exp_succ = 1;
        else                    exp_fails++;
      end else if (script[a] == R_DGOOD) begin
        exp_q.push_back({2'b10, 64'b0, PID_ACK});
        exp_succ = 1;
        exp_data = rsp_data[a];
      end else begin
        if (script[a] == R_DBAD) exp_q.push_back({2'b10, 64'b0, PID_NAK});
        exp_fails++;
      end
    end
    exp_err = (exp_err + exp_fails > 255) ? 255 : exp_err + exp_fails;
  endtask

  task automatic xfer(input bit is_out, input logic [18:0] tok, input logic [71:0] dat);
    int n;
    bit seen;
    predict(is_out, tok, dat);
    tok_seen = 0;
    obs_q.delete();
    tok_cyc.delete();
    n = 0;
    while (!ptcl_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", ptcl_ready, 1'b1);
    token_pkt_in = tok;
    data_pkt_in  = dat;
    xfer_req     = 1'b1;
    @(negedge clk);
    chk("ready_busy", ptcl_ready, 1'b0);
    seen = 0;
    n = 0;
    while (!seen && n < 5000) begin
      token_pkt_in = 19'($urandom);
      data_pkt_in  = {8'($urandom), $urandom, $urandom};
      xfer_req     = 1'($urandom);
      @(negedge clk);
      n++;
      if (ptcl_done) seen = 1;
    end
    xfer_req = 1'b0;
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("success", ptcl_success, exp_succ);
      chk("ptcl_data", ptcl_data, exp_data);
      chk("err_cnt", err_cnt, ERR_EN ? 8'(exp_err) : 8'h00);
      chk("pkt_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        chk($sformatf("pkt%0d", i), obs_q[i], exp_q[i]);
    end
    @(negedge clk);
    chk("done_pulse_end", {ptcl_done, ptcl_ready}, 2'b01);
  endtask

  task automatic fill_script(input int kind);
    for (int i = 0; i < MAX_ATT; i++) begin
      script[i]   = kind;
      rsp_data[i] = {$urandom, $urandom};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {ptcl_ready, ptcl_done, ptcl_success, tx_valid, tx_kind}, 6'b100000);
    chk({tag, "_data"}, ptcl_data, 64'h0);
    chk({tag, "_pkt"}, tx_pkt, 72'h0);
    chk({tag, "_err"}, err_cnt, 8'h00);
  endtask

  initial begin : main
    int n, r, pulses;
    bit is_out;
    xfer_req = 1'b0;
    token_pkt_in = '0;
    data_pkt_in  = '0;
    done_cnt = 0;
    tok_seen = 0;
    fill_script(R_NONE);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // OUT, encoder always ready, immediate ACK
    force_rdly = 0;
    fill_script(R_ACK);
    xfer(1'b1, {PID_OUT, 7'h05, 4'h1}, {PID_DATA, 64'h1122_3344_5566_7788});
    force_rdly = -1;

    // IN, good DATA
    fill_script(R_NONE);
    script[0] = R_DGOOD;
    rsp_data[0] = 64'hDEAD_BEEF_0123_4567;
    xfer(1'b0, {PID_IN, 7'h12, 4'h2}, 72'h0);

    // OUT, NAK x3 then ACK
    fill_script(R_ACK);
    for (int i = 0; i < 3; i++) script[i] = R_NAK;
    xfer(1'b1, {PID_OUT, 7'h33, 4'h3}, {PID_DATA, 64'hCAFE_F00D_0000_0001});

    // IN, no response ever: eight tokens, one full timeout apart
    fill_script(R_NONE);
    xfer(1'b0, {PID_IN, 7'h44, 4'h4}, 72'h0);
    chk("timeout_tokens", tok_cyc.size(), MAX_ATT);
    for (int i = 1; i < tok_cyc.size(); i++)
      chk($sformatf("timeout_gap%0d", i),
          (tok_cyc[i] - tok_cyc[i-1] >= 256) && (tok_cyc[i] - tok_cyc[i-1] <= 275), 1'b1);

    // IN, bad CRC then good DATA
    fill_script(R_DGOOD);
    script[0] = R_DBAD;
    xfer(1'b0, {PID_IN, 7'h55, 4'h5}, 72'h0);

    // Encoder stalls 10 cycles on every packet
    force_rdly = 10;
    fill_script(R_ACK);
    script[0] = R_OTHER;
    xfer(1'b1, {PID_OUT, 7'h66, 4'h6}, {PID_DATA, 64'h0F0F_0F0F_A5A5_5A5A});
    force_rdly = -1;

    // Reset while waiting for a handshake
    fill_script(R_NONE);
    tok_seen = 0;
    done_cnt = 0;
    obs_q.delete();
    token_pkt_in = {PID_OUT, 7'h77, 4'h7};
    data_pkt_in  = {PID_DATA, 64'h1234_5678_9ABC_DEF0};
    xfer_req = 1'b1;
    @(negedge clk);
    xfer_req = 1'b0;
    n = 0;
    while (done_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("data_sent", done_cnt, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_data = '0;
    exp_err  = 0;
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (ptcl_done) pulses++;
    end
    chk("no_done_after_rst", pulses, 0);
    chk("ready_after_rst", ptcl_ready, 1'b1);

    // Randomized requests
    for (int k = 0; k < 25; k++) begin
      is_out = 1'($urandom);
      for (int i = 0; i < MAX_ATT; i++) begin
        r = $urandom_range(0, 99);
        rsp_data[i] = {$urandom, $urandom};
        if (is_out)
          script[i] = (r < 45) ? R_ACK : (r < 75) ? R_NAK : (r < 92) ? R_OTHER : R_NONE;
        else
          script[i] = (r < 40) ? R_DGOOD : (r < 65) ? R_DBAD : (r < 80) ? R_NAK :
                      (r < 92) ? R_OTHER : R_NONE;
      end
      xfer(is_out, {(is_out ? PID_OUT : PID_IN), 7'($urandom), 4'($urandom)},
           {PID_DATA, $urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
